// File: rtl/fifo_stream_reader_if.sv
// Connection bundle between a synchronous fifo and the agent that reads from it.
// The fifo presents dataout one cycle after a read and reports its fill status.
interface fifoConnect #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    typedef struct packed {
        logic                     full;
        logic                     empty;
        logic [$clog2(DEPTH):0]   count;
    } fill_status_t;

    logic             write;
    logic [WIDTH-1:0] datain;
    logic             read;
    logic [WIDTH-1:0] dataout;
    fill_status_t     fillStatus;

    modport reader (
        output write,
        output datain,
        output read,
        input  dataout,
        input  fillStatus
    );

    modport fifo (
        input  write,
        input  datain,
        input  read,
        output dataout,
        output fillStatus
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a requested number of words from a fifo onto a valid/ready stream,
// using a 2-entry skid buffer to absorb the fifo's one-cycle read latency.
module fifo_stream_reader #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int LENBITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    fifoConnect.reader         link,
    input  logic               start,
    input  logic [LENBITS-1:0] length,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [LENBITS-1:0] rd_left_q, rd_left_d;
    logic [LENBITS-1:0] tx_left_q, tx_left_d;
    logic [1:0]         occ_q, occ_d;
    logic               inflight_q;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   skid_q [2];
    logic [WIDTH-1:0]   skid_d [2];

    logic pop;
    logic room;
    logic rd_en;
    logic wr_pos;

    logic unused_ok;
    assign unused_ok = ^{link.fillStatus.full, link.fillStatus.count, 32'(DEPTH)};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_left_q  <= '0;
            tx_left_q  <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_left_q  <= rd_left_d;
            tx_left_q  <= tx_left_d;
            occ_q      <= occ_d;
            inflight_q <= rd_en;
            done_q     <= done_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_skid
            always_ff @(posedge clk) begin
                skid_q[gi] <= skid_d[gi];
            end
        end
    endgenerate

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        rd_left_d = rd_left_q;
        tx_left_d = tx_left_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d   = RUN;
                        rd_left_d = length;
                        tx_left_d = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rd_en) begin
                    rd_left_d = rd_left_q - LENBITS'(1);
                    if (rd_left_q == LENBITS'(1)) state_d = DRAIN;
                end
            end
            default: ;
        endcase
        if (state_q != IDLE && pop) begin
            tx_left_d = tx_left_q - LENBITS'(1);
            if (tx_left_q == LENBITS'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // Skid buffer: entry 0 is the head; a word returned by the fifo lands
    // behind whatever survives this cycle's pop (occ - pop is 0 or 1 here).
    always_comb begin
        skid_d = skid_q;
        wr_pos = occ_q[0] ^ pop;
        if (pop) skid_d[0] = skid_q[1];
        if (inflight_q) skid_d[wr_pos] = link.dataout;
        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    // Outputs; everything visible is forced quiet while reset is held.
    always_comb begin
        m_valid = (occ_q != 2'd0) && !reset;
        pop     = m_valid && m_ready;
        m_data  = skid_q[0];
        m_last  = m_valid && (tx_left_q == LENBITS'(1));
        busy    = (state_q != IDLE) && !reset;
        done    = done_q && !reset;
        // Only read when the word will have a free slot on arrival
        room    = ({1'b0, occ_q} + {2'b0, inflight_q}) < ({2'b0, pop} + 3'd2);
        rd_en   = (state_q == RUN) && (rd_left_q != '0) && !link.fillStatus.empty
                  && room && !reset;
        link.read   = rd_en;
        link.write  = 1'b0;
        link.datain = '0;
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised scoreboard bench: a fifo model feeds the reader, a driver issues
// bursts, and a negedge monitor checks every cycle against a word-sequence model.
module tb_fifo_stream_reader;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 32;
    localparam int LENBITS = 16;
    localparam int NW      = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               start;
    logic [LENBITS-1:0] length;
    logic               busy, done, m_valid, m_ready, m_last;
    logic [WIDTH-1:0]   m_data;

    fifoConnect #(.WIDTH(WIDTH), .DEPTH(DEPTH)) link ();

    fifo_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LENBITS(LENBITS)) dut (
        .clk(clk), .reset(reset), .link(link), .start(start), .length(length),
        .busy(busy), .done(done), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last)
    );

    // Fifo model: the fifo holds a window [rd_ptr, wr_ptr) of one fixed word sequence
    logic [WIDTH-1:0] all_words [NW];
    int   rd_ptr = 0;
    int   wr_ptr = 0;
    logic wr_req = 1'b0;
    int   cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (link.read && rd_ptr < wr_ptr) begin
            link.dataout <= all_words[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
        if (wr_req && (wr_ptr - rd_ptr) < DEPTH && wr_ptr < NW) wr_ptr <= wr_ptr + 1;
    end
    assign link.fillStatus = {(wr_ptr - rd_ptr) == DEPTH, rd_ptr == wr_ptr, 6'(wr_ptr - rd_ptr)};

    // Expectations written by the driver only
    logic [WIDTH-1:0] exp_data [NW];
    logic             exp_last [NW];
    int exp_wr = 0;
    int burst_start_cyc = -1;
    int burst_len = 0;
    int zl_done_cyc = -10;
    int exp_left = -1;
    logic tb_end = 1'b0;

    // Monitor-owned state
    int vectors = 0;
    int miscompares = 0;
    int exp_rd = 0;
    int last_pop_cyc = -10;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, e);
        end
    endtask

    initial begin
        int  m_reads = 0, m_pops = 0, rd_h1 = 0, rd_h2 = 0, wd = 0;
        bit  act, popb, exp_read, exp_valid, exp_done, prev_stall, end_done;
        logic [WIDTH-1:0] prev_data;
        prev_stall = 0;
        end_done = 0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_quiet", {busy, done, m_valid, m_last, link.read}, 5'b0);
                exp_rd = exp_wr;
                m_reads = 0; m_pops = 0; rd_h1 = 0; rd_h2 = 0;
                prev_stall = 0;
                wd = 0;
            end else begin
                if (cyc == burst_start_cyc) begin
                    m_reads = 0; m_pops = 0; rd_h1 = 0; rd_h2 = 0;
                end
                act = burst_start_cyc >= 0 && cyc > burst_start_cyc &&
                      !(last_pop_cyc > burst_start_cyc && cyc > last_pop_cyc);
                popb = m_valid && m_ready;
                exp_read = act && m_reads < burst_len && !link.fillStatus.empty &&
                           (m_reads - m_pops - int'(popb)) < 2;
                chk("read", link.read, exp_read);
                if (link.read) chk("read_when_empty", link.fillStatus.empty, 1'b0);
                exp_valid = act && (rd_h2 - m_pops) > 0;
                chk("m_valid", m_valid, exp_valid);
                chk("busy", busy, act);
                exp_done = (cyc == last_pop_cyc + 1) || (cyc == zl_done_cyc);
                chk("done", done, exp_done);
                if (prev_stall) chk("stall_hold", {m_valid, m_data}, {1'b1, prev_data});
                if (m_valid && exp_rd < exp_wr) chk("m_last", m_last, exp_last[exp_rd]);
                if (popb) begin
                    if (exp_rd >= exp_wr) begin
                        chk("unexpected_word", m_data, 'x);
                    end else begin
                        chk("m_data", m_data, exp_data[exp_rd]);
                        $display("pop cycle %0d data=%08h last=%0d", cyc, m_data, m_last);
                        if (exp_last[exp_rd]) begin
                            last_pop_cyc = cyc;
                            chk("burst_reads", m_reads, burst_len);
                            if (exp_left >= 0) chk("fifo_left", wr_ptr - rd_ptr, exp_left);
                        end
                        exp_rd++;
                    end
                    m_pops++;
                end
                if (link.read) m_reads++;
                rd_h2 = rd_h1;
                rd_h1 = m_reads;
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                wd = act ? wd + 1 : 0;
                if (wd == 1000) chk("burst_timeout", 1'b1, 1'b0);
            end
            if (tb_end && !end_done) begin
                end_done = 1;
                chk("all_words_delivered", exp_rd, exp_wr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            wr_req = 1'b1;
            tick();
        end
        wr_req = 1'b0;
    endtask

    // Assumes the DUT is idle: records the burst then pulses start for one cycle
    task automatic issue(input int len, input int left_after);
        start  = 1'b1;
        length = LENBITS'(len);
        if (len == 0) begin
            zl_done_cyc = cyc + 1;
        end else begin
            for (int k = 0; k < len; k++) begin
                exp_data[exp_wr] = all_words[rd_ptr + k];
                exp_last[exp_wr] = (k == len - 1);
                exp_wr++;
            end
            burst_len       = len;
            burst_start_cyc = cyc;
            exp_left        = left_after;
        end
        $display("start cycle %0d length=%0d", cyc, len);
        tick();
        start = 1'b0;
    endtask

    // mode 1: ready held, 2: ready toggles 1,0,..., 3: random ready
    task automatic wait_idle(input int mode, input int wr_period, input int wr_max, input bit poke);
        int wrote = 0;
        for (int i = 0; i < 1500; i++) begin
            case (mode)
                1:       m_ready = 1'b1;
                2:       m_ready = (i % 2 == 0);
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
            wr_req = (wr_period > 0 && i % wr_period == 0 && wrote < wr_max);
            if (wr_req) wrote++;
            start = poke && (i == 2);
            length = LENBITS'($urandom_range(0, 20));
            tick();
            start  = 1'b0;
            wr_req = 1'b0;
            if (!busy) break;
        end
    endtask

    initial begin
        int n, len;
        for (int i = 0; i < NW; i++) all_words[i] = $urandom;
        reset = 1'b1; start = 1'b0; length = '0; m_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Straight burst from a preloaded fifo
        push_words(8);
        m_ready = 1'b1;
        issue(4, 4);
        wait_idle(1, 0, 0, 0);

        // Sink stalls every other cycle
        push_words(4);
        issue(6, 2);
        wait_idle(2, 0, 0, 0);
        issue(2, 0);
        wait_idle(1, 0, 0, 0);

        // Fifo starts empty and trickles in one word every 4 cycles
        issue(3, 0);
        wait_idle(1, 4, 3, 0);

        // Zero-length request
        issue(0, -1);
        wait_idle(1, 0, 0, 0);
        tick();

        // Reset two cycles after the first word appears
        push_words(14);
        m_ready = 1'b1;
        issue(10, -1);
        for (int i = 0; i < 50 && !m_valid; i++) tick();
        tick();
        tick();
        reset = 1'b1;
        burst_start_cyc = -1;
        tick();
        reset = 1'b0;
        tick();
        issue(2, -1);
        wait_idle(1, 0, 0, 0);

        // Start pulsed while a burst is running
        issue(5, -1);
        wait_idle(3, 0, 0, 1);

        // Random bursts
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 6);
            if ((wr_ptr - rd_ptr) + n <= 16) push_words(n);
            len = $urandom_range(0, 8);
            issue(len, -1);
            wait_idle(3, $urandom_range(1, 4), len, len > 0 && $urandom_range(0, 1) == 1);
            tick();
        end

        tb_end = 1'b1;
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width, matching the attached fifoConnect.
REQ-002 SHALL have parameter DEPTH, default 32: DEPTH of the attached fifoConnect.
REQ-003 SHALL have parameter LENBITS, default 16: width of the burst length.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1: clock, all state on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have port link, fifoConnect.reader, WIDTH/DEPTH: the reader end of one fifo.
REQ-008 SHALL have port start, input, 1: one-cycle request to drain a burst.
REQ-009 SHALL have port length, input, LENBITS: number of words in the burst, sampled with start.
REQ-010 SHALL have port busy, output, 1: high from start acceptance until done.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when a burst completes.
REQ-012 SHALL have port m_data, output, WIDTH: stream data.
REQ-013 SHALL have port m_valid, output, 1: stream data valid.
REQ-014 SHALL have port m_ready, input, 1: sink accepts the word when m_valid && m_ready.
REQ-015 SHALL have port m_last, output, 1: marks the final word of a burst.

Function
REQ-016 SHALL drive link.write=0 and link.datain=0 at all times.
REQ-017 SHALL implement states IDLE, RUN and DRAIN.
REQ-018 SHALL move from IDLE to RUN on start with length!=0, latching length into rd_left and tx_left (LENBITS each).
REQ-019 SHALL, on start with length==0 in IDLE, pulse done in the next cycle, issue no read, and stay in IDLE.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL assert link.read only in RUN, only when rd_left!=0 and link.fillStatus.empty==0, and only when (occ + inflight - pop) < 2.
REQ-022 In REQ-021, occ is the skid-buffer entry count (0..2), inflight is a register equal to the previous cycle's link.read, and pop = m_valid && m_ready.
REQ-023 SHALL never assert link.read when link.fillStatus.empty==1.
REQ-024 SHALL decrement rd_left on each cycle link.read is high.
REQ-025 SHALL enter DRAIN when rd_left reaches 0.
REQ-026 SHALL treat fifo read latency as 1 cycle: a read in cycle N presents link.dataout in cycle N+1, which is written into the 2-entry skid buffer at the end of N+1.
REQ-027 SHALL present the skid-buffer head on m_data with m_valid=(occ!=0): first m_valid in cycle N+2 after the first read in cycle N.
REQ-028 SHALL sustain 1 word/cycle while m_ready=1 and the fifo is non-empty.
REQ-029 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-030 SHALL handle a simultaneous push and pop of the skid buffer in one cycle with occ unchanged.
REQ-031 SHALL decrement tx_left on each pop.
REQ-032 SHALL assert m_last = m_valid && (tx_left==1).
REQ-033 SHALL, on the pop with tx_left==1, return to IDLE, drop busy and pulse done in the following cycle.
REQ-034 SHALL set busy = (state!=IDLE).
REQ-035 SHALL never overflow the skid buffer: occ never exceeds 2, and no capture is lost under any m_ready pattern.
REQ-036 SHALL, when the fifo runs empty mid-burst, stall reads without error and resume reading when empty deasserts.

Reset
REQ-037 SHALL, in any cycle with reset=1, go to IDLE with occ=0, inflight=0, rd_left=0 and tx_left=0.
REQ-038 SHALL drive m_valid=0, m_last=0, busy=0, done=0 and link.read=0 during reset and in the first cycle after it.
REQ-039 SHALL discard words already read from the fifo when reset occurs mid-burst.
REQ-040 SHALL leave m_data unconstrained while m_valid=0.

Verification
REQ-041 Bench SHALL cover: fifo preloaded with 8 words 0..7, start length=4, m_ready=1 -> reads in 4 consecutive cycles starting 1 cycle after start; m_data 0,1,2,3 on consecutive cycles; m_last with 3; done 1 cycle later; 4 words left in the fifo.
REQ-042 Bench SHALL cover: length=6, m_ready toggling 1,0,1,0 -> all 6 words in order, none duplicated or dropped, occ<=2, m_data stable while stalled.
REQ-043 Bench SHALL cover: fifo empty, start length=3, writer pushes one word every 4 cycles -> link.read never high with empty=1, 3 words delivered, done after the third.
REQ-044 Bench SHALL cover: start length=0 -> done 1 cycle later, no read, busy never high.
REQ-045 Bench SHALL cover: reset asserted 2 cycles after the first m_valid of a length=10 burst -> next cycle m_valid=0, busy=0, read=0; a new start length=2 then delivers the next 2 fifo words.
REQ-046 Bench SHALL cover: start pulsed during a busy burst -> ignored, no change in read count or length.
